life_grid: RTL and testbench

LIFE_GRID -- requirements
Module: life_grid

---
 rtl/life_grid_pkg.sv | 15 +
 rtl/life_row_next.sv | 39 +++
 rtl/life_grid.sv | 145 ++++++++++++++
 tb/tb_life_grid.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/life_grid_pkg.sv
// Shared types and rule constants for the life_grid cellular automaton.
package life_pkg;

   // Generation sequencer states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      COMMIT = 2'd2
   } life_state_t;

   // Conway's rule: born with exactly 3, survive with 2 or 3
   localparam logic [8:0] RULE_B3  = 9'b000001000;
   localparam logic [8:0] RULE_S23 = 9'b000001100;

endpackage

// File: rtl/life_row_next.sv
// Combinational next-state for one row, given the rows above and below.
module life_row_next #(
   parameter int WIDTH = 8,
   parameter bit WRAP  = 1'b1
) (
   input  logic [WIDTH-1:0] north,
   input  logic [WIDTH-1:0] centre,
   input  logic [WIDTH-1:0] south,
   input  logic [8:0]       birth_mask,
   input  logic [8:0]       survive_mask,
   output logic [WIDTH-1:0] next_row
);

   // Rows padded by one column each side: index 0 is column -1, index WIDTH+1 is column WIDTH
   logic [WIDTH+1:0] n_ext;
   logic [WIDTH+1:0] c_ext;
   logic [WIDTH+1:0] s_ext;
   logic [3:0]       count;

   // Build padded rows, wrapping or zero-filling the edge columns
   always_comb begin
      n_ext = {(WRAP ? north[0]  : 1'b0), north,  (WRAP ? north[WIDTH-1]  : 1'b0)};
      c_ext = {(WRAP ? centre[0] : 1'b0), centre, (WRAP ? centre[WIDTH-1] : 1'b0)};
      s_ext = {(WRAP ? south[0]  : 1'b0), south,  (WRAP ? south[WIDTH-1]  : 1'b0)};
   end

   // Count the eight neighbours of each column and apply the birth/survive masks
   always_comb begin
      count    = '0;
      next_row = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         count = {3'b000, n_ext[i]} + {3'b000, n_ext[i+1]} + {3'b000, n_ext[i+2]}
               + {3'b000, c_ext[i]}                          + {3'b000, c_ext[i+2]}
               + {3'b000, s_ext[i]} + {3'b000, s_ext[i+1]} + {3'b000, s_ext[i+2]};
         next_row[i] = centre[i] ? survive_mask[count] : birth_mask[count];
      end
   end

endmodule

// File: rtl/life_grid.sv
// Game-of-life grid: row-serial generation update into a shadow buffer, then bulk commit.
module life_grid
   import life_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter bit WRAP   = 1'b1,
   parameter int GEN_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [8:0]                birth_mask,
   input  logic [8:0]                survive_mask,
   input  logic                      step,
   output logic                      step_ready,
   input  logic                      wr_en,
   input  logic [$clog2(HEIGHT)-1:0] wr_row,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic [$clog2(HEIGHT)-1:0] rd_row,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      busy,
   output logic                      done,
   output logic [GEN_W-1:0]          generation,
   output logic                      stable,
   output logic                      extinct
);

   localparam int RW = $clog2(HEIGHT);
   localparam logic [RW-1:0] LAST = RW'(HEIGHT - 1);

   life_state_t      state;
   life_state_t      state_nx;
   logic [WIDTH-1:0] grid [HEIGHT];
   logic [WIDTH-1:0] nbuf [HEIGHT];
   logic [RW-1:0]    row;
   logic [8:0]       birth_q;
   logic [8:0]       survive_q;
   logic             changed;
   logic [WIDTH-1:0] north;
   logic [WIDTH-1:0] centre;
   logic [WIDTH-1:0] south;
   logic [WIDTH-1:0] row_next;
   logic             accept;
   logic             write;
   logic             any_alive;

   // done is gated in so that step_ready returns the cycle after the done pulse
   assign step_ready = (state == IDLE) && !wr_en && !done;
   assign accept     = step && step_ready;
   assign write      = wr_en && (state == IDLE) && (32'(wr_row) < HEIGHT);
   assign busy       = (state != IDLE);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = SCAN;
         SCAN:    if (row == LAST) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Select the current row and its vertical neighbours from the unmodified grid
   always_comb begin
      centre = grid[row];
      if (row == '0) north = WRAP ? grid[LAST] : '0;
      else           north = grid[row - 1'b1];
      if (row == LAST) south = WRAP ? grid[0] : '0;
      else             south = grid[row + 1'b1];
   end

   life_row_next #(
      .WIDTH (WIDTH),
      .WRAP  (WRAP)
   ) u_row_next (
      .north        (north),
      .centre       (centre),
      .south        (south),
      .birth_mask   (birth_q),
      .survive_mask (survive_q),
      .next_row     (row_next)
   );

   // Grid, buffer, row counter, rule latch and status registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned r = 0; r < HEIGHT; r++) begin
            grid[r] <= '0;
            nbuf[r] <= '0;
         end
         row        <= '0;
         birth_q    <= '0;
         survive_q  <= '0;
         changed    <= 1'b0;
         generation <= '0;
         stable     <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (write) begin
                  grid[wr_row] <= wr_data;
                  stable       <= 1'b0;
               end else if (accept) begin
                  birth_q   <= birth_mask;
                  survive_q <= survive_mask;
                  row       <= '0;
                  changed   <= 1'b0;
               end
            end
            SCAN: begin
               nbuf[row] <= row_next;
               changed   <= changed | (row_next != centre);
               if (row != LAST) row <= row + 1'b1;
            end
            COMMIT: begin
               for (int unsigned r = 0; r < HEIGHT; r++) grid[r] <= nbuf[r];
               generation <= generation + 1'b1;
               done       <= 1'b1;
               stable     <= !changed;
            end
            default: ;
         endcase
      end
   end

   // Combinational readout
   assign rd_data = (32'(rd_row) < HEIGHT) ? grid[rd_row] : '0;

   // Extinct when no row holds a live cell
   always_comb begin
      any_alive = 1'b0;
      for (int unsigned r = 0; r < HEIGHT; r++) any_alive = any_alive | (|grid[r]);
      extinct = !any_alive;
   end

endmodule

// File: tb/tb_life_grid.sv
// Directed bench for life_grid: one toroidal and one dead-edge instance share stimulus.
module tb_life_grid;
   import life_pkg::*;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int GW = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [8:0]    birth_mask;
   logic [8:0]    survive_mask;
   logic          step;
   logic          wr_en;
   logic [2:0]    wr_row;
   logic [W-1:0]  wr_data;
   logic [2:0]    rd_row;

   logic          step_ready_w, busy_w, done_w, stable_w, extinct_w;
   logic [W-1:0]  rd_data_w;
   logic [GW-1:0] generation_w;
   logic          step_ready_c, busy_c, done_c, stable_c, extinct_c;
   logic [W-1:0]  rd_data_c;
   logic [GW-1:0] generation_c;

   int            n_checks = 0;
   int            n_errors = 0;
   int            gen_exp  = 0;
   int            done_seen;
   logic [W-1:0]  pat [H];

   always #5 clk = ~clk;

   life_grid #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b1), .GEN_W(GW)) dut_w (
      .clk(clk), .reset_n(reset_n), .birth_mask(birth_mask), .survive_mask(survive_mask),
      .step(step), .step_ready(step_ready_w), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .rd_row(rd_row), .rd_data(rd_data_w), .busy(busy_w),
      .done(done_w), .generation(generation_w), .stable(stable_w), .extinct(extinct_w)
   );

   life_grid #(.WIDTH(W), .HEIGHT(H), .WRAP(1'b0), .GEN_W(GW)) dut_c (
      .clk(clk), .reset_n(reset_n), .birth_mask(birth_mask), .survive_mask(survive_mask),
      .step(step), .step_ready(step_ready_c), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .rd_row(rd_row), .rd_data(rd_data_c), .busy(busy_c),
      .done(done_c), .generation(generation_c), .stable(stable_c), .extinct(extinct_c)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_grid(input string tag, input bit clamp);
      for (int r = 0; r < H; r++) begin
         rd_row = 3'(r);
         #1;
         check_eq($sformatf("%s row%0d", tag, r), clamp ? rd_data_c : rd_data_w, pat[r]);
      end
   endtask

   task automatic clear_pat();
      for (int r = 0; r < H; r++) pat[r] = '0;
   endtask

   task automatic write_row(input int r, input logic [W-1:0] d);
      @(negedge clk);
      wr_en   = 1'b1;
      wr_row  = 3'(r);
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic clear_grid();
      for (int r = 0; r < H; r++) write_row(r, '0);
   endtask

   // One generation; masks are scrambled while busy to show they were latched
   task automatic do_step(input bit poke);
      int         n;
      logic [8:0] b_save;
      logic [8:0] s_save;
      n = 0;
      @(negedge clk);
      while (!step_ready_w && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("step_ready before step", step_ready_w, 1);
      step = 1'b1;
      @(negedge clk);
      step   = 1'b0;
      b_save = birth_mask;
      s_save = survive_mask;
      birth_mask   = ~b_save;
      survive_mask = ~s_save;
      gen_exp++;
      n = 0;
      while (!done_w && n < 40) begin
         if (poke && n == 3) begin
            wr_en   = 1'b1;
            wr_row  = 3'd0;
            wr_data = 8'hFF;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      wr_en = 1'b0;
      check_eq("done latency", n, H + 1);
      check_eq("ready during done", step_ready_w, 0);
      check_eq("dead-edge done aligned", done_c, 1);
      @(negedge clk);
      check_eq("ready after done", step_ready_w, 1);
      check_eq("done single pulse", done_w, 0);
      birth_mask   = b_save;
      survive_mask = s_save;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_n      = 1'b0;
      birth_mask   = RULE_B3;
      survive_mask = RULE_S23;
      step         = 1'b0;
      wr_en        = 1'b0;
      wr_row       = '0;
      wr_data      = '0;
      rd_row       = '0;
      #22;
      // Reset state
      clear_pat();
      check_grid("reset", 1'b0);
      check_eq("reset generation", generation_w, 0);
      check_eq("reset stable", stable_w, 0);
      check_eq("reset done", done_w, 0);
      check_eq("reset extinct", extinct_w, 1);
      check_eq("reset busy", busy_w, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Blinker oscillates with period 2
      write_row(3, 8'h1C);
      #1 check_eq("blinker extinct", extinct_w, 0);
      do_step(1'b0);
      clear_pat();
      pat[2] = 8'h08; pat[3] = 8'h08; pat[4] = 8'h08;
      check_grid("blinker gen1", 1'b0);
      check_grid("blinker gen1 dead-edge", 1'b1);
      check_eq("blinker generation", generation_w, gen_exp);
      check_eq("blinker stable", stable_w, 0);
      do_step(1'b0);
      clear_pat();
      pat[3] = 8'h1C;
      check_grid("blinker gen2", 1'b0);
      check_eq("blinker generation 2", generation_w, gen_exp);

      // Block is still life; a write attempted mid-scan is ignored
      clear_grid();
      write_row(1, 8'h06);
      write_row(2, 8'h06);
      do_step(1'b1);
      clear_pat();
      pat[1] = 8'h06; pat[2] = 8'h06;
      check_grid("block", 1'b0);
      check_eq("block stable", stable_w, 1);
      check_eq("block extinct", extinct_w, 0);
      write_row(5, 8'h00);
      #1 check_eq("write clears stable", stable_w, 0);

      // Glider returns home after 32 generations on the torus
      clear_grid();
      write_row(0, 8'h02);
      write_row(1, 8'h04);
      write_row(2, 8'h07);
      for (int s = 0; s < 32; s++) do_step(1'b0);
      clear_pat();
      pat[0] = 8'h02; pat[1] = 8'h04; pat[2] = 8'h07;
      check_grid("glider torus", 1'b0);
      check_eq("glider generation", generation_w, gen_exp);
      check_eq("dead-edge generation", generation_c, gen_exp);
      for (int s = 0; s < 16; s++) do_step(1'b0);
      check_eq("dead-edge glider extinct", extinct_c, 0);
      check_eq("dead-edge glider stable", stable_c, 1);

      // B1/S-empty on a single centre cell
      clear_grid();
      birth_mask   = 9'b000000010;
      survive_mask = 9'b000000000;
      write_row(4, 8'h10);
      do_step(1'b0);
      clear_pat();
      pat[3] = 8'h38; pat[4] = 8'h28; pat[5] = 8'h38;
      check_grid("b1 centre", 1'b0);
      birth_mask   = RULE_B3;
      survive_mask = RULE_S23;

      // Step together with a write in IDLE is not accepted
      @(negedge clk);
      step    = 1'b1;
      wr_en   = 1'b1;
      wr_row  = 3'd0;
      wr_data = 8'h81;
      #1 check_eq("ready with wr_en", step_ready_w, 0);
      @(negedge clk);
      step  = 1'b0;
      wr_en = 1'b0;
      check_eq("step blocked busy", busy_w, 0);
      rd_row = 3'd0;
      #1 check_eq("write during step", rd_data_w, 8'h81);
      check_eq("blocked generation", generation_w, gen_exp);

      // Reset in the middle of a scan aborts cleanly
      @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("mid-scan busy", busy_w, 1);
      reset_n = 1'b0;
      gen_exp = 0;
      #1;
      clear_pat();
      check_grid("abort", 1'b0);
      check_eq("abort generation", generation_w, gen_exp);
      check_eq("abort busy", busy_w, 0);
      check_eq("abort extinct", extinct_w, 1);
      done_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (done_w) done_seen++;
      end
      reset_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done_w) done_seen++;
      end
      check_eq("abort no done", done_seen, 0);
      check_eq("abort generation held", generation_w, gen_exp);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
